io_debounce: RTL
================

Name: io_debounce

Overview:
- Input-side counterpart of the board display path: conditions raw board inputs (IO_SW switches/buttons) before they reach design logic.
- Per channel: 2-flop synchronizer, debounce state machine, clean level, one-cycle rise/fall pulses.
- Sits between the top-level IO_SW pins and counters/controllers, e.g. a count-enable feeding io_lcd.

Parameters:
- WIDTH, 5, number of independent input channels
- DEBOUNCE_CYCLES, 1000000, synchronized input must hold a new value this many consecutive clocks to be accepted (10 ms at 100 MHz); legal range 2..2^24
- REPEAT_DELAY, 50000000, clocks held high before first auto-repeat pulse (optional feature only)
- REPEAT_PERIOD, 10000000, clocks between subsequent auto-repeat pulses (optional feature only)

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- i_raw  input  WIDTH  raw asynchronous pin inputs
- o_level  output  WIDTH  debounced level per channel
- o_rise  output  WIDTH  one-cycle pulse when o_level goes 0->1 (plus repeat pulses if enabled)
- o_fall  output  WIDTH  one-cycle pulse when o_level goes 1->0
- o_any  output  1  OR of o_rise, registered with the pulses

Behaviour:
- One clock (clk). Reset is asynchronous and active-high on rst. All flops clear while rst is high: synchronizers 0, counters 0, state S_LO, o_level/o_rise/o_fall/o_any 0.
- Synchronizer: two flops per bit; "s" = second-stage output. No logic on the first stage.
- Per-channel FSM with states S_LO, S_WAIT_HI, S_HI, S_WAIT_LO. Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - S_LO: s=1 -> S_WAIT_HI, cnt=1. s=0 -> stay.
  - S_WAIT_HI: s=0 -> S_LO, cnt=0 (glitch rejected, no outputs). s=1 and cnt==DEBOUNCE_CYCLES-1 -> S_HI, o_level<=1, o_rise<=1 for one cycle. Otherwise cnt+1.
  - S_HI and S_WAIT_LO mirror these with polarity swapped. Commit sets o_level<=0 and o_fall<=1.
- Latency: raw step held stable -> o_level changes exactly 2+DEBOUNCE_CYCLES clocks after the first sampling edge that captures the new raw value. o_rise/o_fall assert in the same cycle o_level changes.
- Pulses are exactly one cycle wide. rise and fall never assert together on one channel. Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Counter never wraps: it is cleared on every state change and saturates by construction at DEBOUNCE_CYCLES-1.
- Reset mid-debounce aborts the attempt. After release the channel restarts from S_LO. An input already high at release yields o_rise after 2+DEBOUNCE_CYCLES clocks.
- Bounce (s toggling faster than DEBOUNCE_CYCLES) keeps o_level at its old value indefinitely.

Optional Feature:
- Macro: IO_DEBOUNCE_AUTOREPEAT_EN.
- Defined: a per-channel repeat counter starts when o_level rises. After REPEAT_DELAY clocks in S_HI (including S_WAIT_LO excursions that return to S_HI), o_rise pulses again, then every REPEAT_PERIOD clocks while o_level=1. The counter clears when o_level falls or on reset. Repeat pulses also drive o_any.
- Not defined: no repeat counters are synthesized. o_rise pulses only on the debounced 0->1 transition.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, WIDTH=5):
- Clean step i_raw[0] 0->1 held -> o_level[0]=1 and a single o_rise[0] pulse exactly 10 clocks after the capturing edge; o_fall stays 0; other channels stay 0.
- Bounce i_raw[1] toggled every 3 clocks for 40 clocks, then held 1 -> no pulses during the bounce; a single o_rise[1] 10 clocks after the final stable edge.
- Glitch: i_raw[2]=1 for 5 clocks, then 0 -> o_level[2] stays 0, no pulses, FSM returns to S_LO.
- Release: channel 0 high, then raw 1->0 held -> o_fall[0] one-cycle pulse 10 clocks later, o_level[0]=0.
- Async reset asserted mid-count (cnt=5) and between clock edges with raw still 1 -> outputs 0 immediately; after release, o_rise 10 clocks later.
- With IO_DEBOUNCE_AUTOREPEAT_EN, channel held high for 40 clocks after commit -> o_rise at commit, +20, +25, +30, +35, +40; no further pulses after release.

Source files
------------

// File: rtl/io_debounce.sv
// ---------------------------------------------------------------------------
// io_debounce
//
// Conditions raw board inputs (switches/buttons) before they reach design
// logic. Each channel has the same independent pipeline:
//   raw pin -> 2-flop synchronizer -> debounce FSM -> registered output stage
// The output stage turns the settled FSM state into a clean level plus
// one-cycle rise/fall pulses.
//
// Latency: a clean raw step held stable changes o_level exactly
// 2 + DEBOUNCE_CYCLES clocks after the edge that first captures it. That is
// one synchronizer stage, DEBOUNCE_CYCLES FSM samples and one output register.
//
// Optional feature (compile-time macro IO_DEBOUNCE_AUTOREPEAT_EN):
//   When defined, a channel held high re-pulses o_rise REPEAT_DELAY clocks
//   after its level rose, then every REPEAT_PERIOD clocks while it stays high.
//   When undefined, no repeat counters exist and o_rise only marks the
//   debounced 0->1 transition.
//
// Parameters:
//   WIDTH           number of independent channels
//   DEBOUNCE_CYCLES clocks a new synchronized value must hold (2 .. 2^24)
//   REPEAT_DELAY    clocks high before the first repeat pulse (autorepeat)
//   REPEAT_PERIOD   clocks between later repeat pulses, 1 .. REPEAT_DELAY
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset
//   i_raw    raw asynchronous pin inputs, one bit per channel
//   o_level  debounced level per channel
//   o_rise   one-cycle pulse on a debounced 0->1 (plus repeats if enabled)
//   o_fall   one-cycle pulse on a debounced 1->0
//   o_any    OR of o_rise, registered together with the pulses
// ---------------------------------------------------------------------------
module io_debounce #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_any
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LO      = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HI      = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;

  logic [WIDTH-1:0] syncMeta_q;
  logic [WIDTH-1:0] syncOut_q;

  state_e           state_q [WIDTH];
  state_e           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];

  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] rise_q,  rise_d;
  logic [WIDTH-1:0] fall_q,  fall_d;
  logic             any_q,   any_d;
  logic [WIDTH-1:0] repHit;

  // Two-stage synchronizer. The first stage may go metastable, so nothing
  // but the second stage ever looks at it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncMeta_q <= '0;
      syncOut_q  <= '0;
    end else begin
      syncMeta_q <= i_raw;
      syncOut_q  <= syncMeta_q;
    end
  end

  // Debounce state and hold counter for every channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= S_LO;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic. Entering a WAIT state loads 1 because that sample
  // already counts as the first one at the new value. Every exit from a WAIT
  // state clears the counter, so it never passes DEBOUNCE_CYCLES-1 and never
  // wraps.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        S_LO: begin
          if (syncOut_q[i]) begin
            state_d[i] = S_WAIT_HI;
            cnt_d[i]   = CNT_ONE;
          end
        end
        S_WAIT_HI: begin
          if (!syncOut_q[i]) begin
            state_d[i] = S_LO;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_HI;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        S_HI: begin
          if (!syncOut_q[i]) begin
            state_d[i] = S_WAIT_LO;
            cnt_d[i]   = CNT_ONE;
          end
        end
        S_WAIT_LO: begin
          if (syncOut_q[i]) begin
            state_d[i] = S_HI;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = S_LO;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = S_LO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`ifdef IO_DEBOUNCE_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [REP_W-1:0] repCnt_q [WIDTH];
  logic [REP_W-1:0] repCnt_d [WIDTH];

  // Repeat counter per channel. It counts clocks with the level held high.
  // A WAIT_LO excursion keeps the level high, so it keeps counting. After the
  // first hit it reloads so the following hits are REPEAT_PERIOD apart.
  // It clears the moment the level drops.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      repHit[i]   = level_q[i] && level_d[i] && (repCnt_q[i] == REP_LAST);
      repCnt_d[i] = repCnt_q[i] + REP_ONE;
      if (!level_q[i] || !level_d[i]) begin
        repCnt_d[i] = '0;
      end else if (repHit[i]) begin
        repCnt_d[i] = REP_RELOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        repCnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        repCnt_q[i] <= repCnt_d[i];
      end
    end
  end
`else
  assign repHit = '0;
`endif

  // Output stage. The level is high whenever the FSM has committed high,
  // including a pending WAIT_LO. The pulses come from comparing that level
  // with its registered copy, so rise and fall can never coincide on one
  // channel.
  always_comb begin
    level_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      level_d[i] = (state_q[i] == S_HI) || (state_q[i] == S_WAIT_LO);
    end
    rise_d = (level_d & ~level_q) | repHit;
    fall_d = ~level_d & level_q;
    any_d  = |rise_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= any_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;
  assign o_any   = any_q;

endmodule
